// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divide datapath; otherwise divides return 0.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  sa_q, sa_d;
  logic                  sb_q, sb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic                  dz_q, dz_d;

  logic                  is_div;
  logic                  sgn_a, sgn_b;
  logic                  neg_a, neg_b;
  logic [XLEN-1:0]       mag_a, mag_b;

  assign is_div = funct3[2];
  assign sgn_a  = is_div ? ~funct3[0]
                         : (funct3[1:0] != 2'b11);
  assign sgn_b  = is_div ? ~funct3[0] : ~funct3[1];
  assign neg_a  = sgn_a & rs1[XLEN-1];
  assign neg_b  = sgn_b & rs2[XLEN-1];
  assign mag_a  = neg_a ? -rs1 : rs1;
  assign mag_b  = neg_b ? -rs2 : rs2;

  // acc holds {partial product high, multiplier} during multiply
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_nxt;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       mul_res;
  logic [XLEN-1:0]       fix_res;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + {1'b0, {XLEN{acc_q[0]}} & b_q};
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  // acc holds {remainder, dividend/quotient} during divide
  logic                  b_zero, ovf;
  logic [XLEN:0]         rem_sh, diff;
  logic [2*XLEN-1:0]     div_nxt;
  logic [XLEN-1:0]       quo, rem;

  assign b_zero  = (rs2 == '0);
  assign ovf     = ~funct3[0] & (rs1 == MIN) & (&rs2);
  assign rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign div_nxt = diff[XLEN]
    ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
    : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign quo = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0]
                             : acc_q[XLEN-1:0];
  assign rem = sa_q ? -acc_q[2*XLEN-1:XLEN]
                    : acc_q[2*XLEN-1:XLEN];
`endif

  always_comb begin
    prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];
    fix_res = op_q[2] ? '0 : mul_res;
`ifdef MDU_DIV_EN
    if (op_q[2]) fix_res = op_q[1] ? rem : quo;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    dz_d    = dz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d    = funct3;
            sa_d    = neg_a;
            sb_d    = neg_b;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            b_d     = mag_b;
            dz_d    = 1'b0;
            state_d = S_CALC;
`ifdef MDU_DIV_EN
            if (is_div && b_zero) begin
              state_d = S_DONE;
              res_d   = funct3[1] ? rs1 : '1;
              dz_d    = 1'b1;
            end else if (is_div && ovf) begin
              state_d = S_DONE;
              res_d   = funct3[1] ? '0 : rs1;
            end
`else
            if (is_div) begin
              state_d = S_DONE;
              res_d   = '0;
            end
`endif
          end
        end
        S_CALC: begin
`ifdef MDU_DIV_EN
          acc_d = op_q[2] ? div_nxt : mul_nxt;
`else
          acc_d = mul_nxt;
`endif
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        end
        S_FIX: begin
          res_d   = fix_res;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign div_zero  = dz_q;

endmodule
